// File: rtl/vector_mem_unit.sv
// vector_mem_unit: vector load/store engine between the vector issue stage
// and the DTIM port. Handles unit-stride and constant-stride loads/stores of
// VLEN 32-bit elements, one memory beat per cycle, one beat outstanding.
//
// Optional feature macro: VECTOR_MEM_UNIT_MASK_EN adds a per-element
// req_mask input. Masked-off elements issue no strided beat and read as 0.
//
// Handshakes: every channel uses valid/ready. A transfer happens on a rising
// clock edge where both are high; the sender holds its payload stable while
// valid is high and ready is low. mem_resp has no ready and is taken only in
// WAIT.
//
// dbg_state exposes the FSM state (0 IDLE, 1 CHECK, 2 ISSUE, 3 WAIT, 4 DONE).

module vector_mem_unit #(
    parameter int VLEN       = 2,
    parameter int MEM_WIDTH  = 32 * VLEN,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_store,
    input  logic                      req_strided,
    input  logic [ADDR_WIDTH-1:0]     req_base,
    input  logic [ADDR_WIDTH-1:0]     req_stride,
    input  logic [4:0]                req_vd,
    input  logic [32*VLEN-1:0]        req_wdata,
`ifdef VECTOR_MEM_UNIT_MASK_EN
    input  logic [VLEN-1:0]           req_mask,
`endif
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [ADDR_WIDTH-1:0]     mem_req_addr,
    output logic                      mem_req_wen,
    output logic [MEM_WIDTH-1:0]      mem_req_wdata,
    output logic [MEM_WIDTH/8-1:0]    mem_req_wmask,
    input  logic                      mem_resp_valid,
    input  logic [MEM_WIDTH-1:0]      mem_resp_data,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [4:0]                resp_vd,
    output logic [32*VLEN-1:0]        resp_data,
    output logic                      resp_error,
    output logic [2:0]                dbg_state
);

    localparam int DW     = 32 * VLEN;
    localparam int BW     = MEM_WIDTH / 8;
    localparam int LANES  = MEM_WIDTH / 32;
    localparam int UBEATS = (DW + MEM_WIDTH - 1) / MEM_WIDTH;
    localparam int PW     = UBEATS * MEM_WIDTH;
    localparam int MAXN   = (VLEN > UBEATS) ? VLEN : UBEATS;
    localparam int CW     = $clog2(MAXN + 1);
    localparam logic [ADDR_WIDTH-1:0] BEAT_MASK = ADDR_WIDTH'(BW - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                state, state_next;
    logic                  out_en;
    logic                  op_store;
    logic                  op_strided;
    logic [ADDR_WIDTH-1:0] op_stride;
    logic [4:0]            op_vd;
    logic [PW-1:0]         op_wdata;
    logic [VLEN-1:0]       op_mask;
    logic                  op_err;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [CW-1:0]         cnt;
    logic [PW-1:0]         asm_buf;

    logic [VLEN-1:0]       req_mask_eff;
    logic [ADDR_WIDTH-1:0] lane_idx;
    logic [31:0]           elem_word;
    int                    beat_shift;
    logic [MEM_WIDTH-1:0]  unit_slice;
    logic [BW-1:0]         unit_wmask;
    logic [DW-1:0]         elem_bits;
    logic                  elem_active;
    logic                  last_beat;
    logic                  fault;
    logic                  accept;
    logic                  issue_go;
    logic                  resp_go;
    logic [ADDR_WIDTH-1:0] step;

`ifdef VECTOR_MEM_UNIT_MASK_EN
    assign req_mask_eff = req_mask;
`else
    assign req_mask_eff = '1;
`endif

    function automatic logic mask_at(input logic [VLEN-1:0] m, input int e);
        logic [VLEN-1:0] t;
        t = m >> e;
        return t[0];
    endfunction

    // Element/beat geometry derived from the running element address and counter
    assign lane_idx    = (cur_addr >> 2) & ADDR_WIDTH'(LANES - 1);
    assign elem_word   = 32'(op_wdata >> {cnt, 5'b0});
    assign beat_shift  = int'(cnt) * MEM_WIDTH;
    assign unit_slice  = MEM_WIDTH'(op_wdata >> beat_shift);
    assign elem_active = op_strided ? mask_at(op_mask, int'(cnt)) : 1'b1;
    assign last_beat   = op_strided ? (cnt == CW'(VLEN - 1)) : (cnt == CW'(UBEATS - 1));
    assign step        = op_strided ? op_stride : ADDR_WIDTH'(BW);
    assign fault       = op_strided ? ((cur_addr[1:0] | op_stride[1:0]) != 2'b00)
                                    : ((cur_addr & BEAT_MASK) != '0);
    assign accept      = req_valid && req_ready;
    assign issue_go    = (state == S_ISSUE) && (!elem_active || (mem_req_ready && op_store));
    assign resp_go     = (state == S_WAIT) && mem_resp_valid;

    // Byte enables of a unit-stride beat: active elements inside the vector only
    always_comb begin
        unit_wmask = '0;
        for (int l = 0; l < LANES; l++) begin
            if ((int'(cnt) * LANES + l) < VLEN && mask_at(op_mask, int'(cnt) * LANES + l)) begin
                unit_wmask = unit_wmask | (BW'(4'hF) << (4 * l));
            end
        end
    end

    // Bit mask of active elements, used to zero masked-off load results
    always_comb begin
        elem_bits = '0;
        for (int e = 0; e < VLEN; e++) begin
            if (mask_at(op_mask, e)) begin
                elem_bits = elem_bits | (DW'(32'hFFFF_FFFF) << (32 * e));
            end
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) state_next = S_CHECK;
            end
            S_CHECK: begin
                if (fault || op_mask == '0) state_next = S_DONE;
                else                        state_next = S_ISSUE;
            end
            S_ISSUE: begin
                if (issue_go)           state_next = last_beat ? S_DONE : S_ISSUE;
                else if (mem_req_ready) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (resp_go) state_next = last_beat ? S_DONE : S_ISSUE;
            end
            S_DONE: begin
                if (resp_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Output logic: everything is a function of state and the latched operation
    always_comb begin
        dbg_state     = state;
        req_ready     = (state == S_IDLE) && out_en;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        mem_req_wen   = 1'b0;
        mem_req_wdata = '0;
        mem_req_wmask = '0;
        resp_valid    = 1'b0;
        resp_vd       = '0;
        resp_data     = '0;
        resp_error    = 1'b0;
        if (state == S_ISSUE) begin
            mem_req_valid = elem_active;
            mem_req_addr  = cur_addr & ~BEAT_MASK;
            mem_req_wen   = op_store;
            if (op_store) begin
                if (op_strided) begin
                    mem_req_wdata = MEM_WIDTH'(elem_word) << {lane_idx, 5'b0};
                    mem_req_wmask = BW'(4'hF) << {lane_idx, 2'b0};
                end else begin
                    mem_req_wdata = unit_slice;
                    mem_req_wmask = unit_wmask;
                end
            end
        end
        if (state == S_DONE) begin
            resp_valid = 1'b1;
            resp_vd    = op_vd;
            resp_error = op_err;
            if (!op_store && !op_err) resp_data = DW'(asm_buf) & elem_bits;
        end
    end

    // Keeps req_ready low while reset is held and for the release cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) out_en <= 1'b0;
        else        out_en <= 1'b1;
    end

    // Request latch, element counter, address walker and load assembly buffer
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_store   <= 1'b0;
            op_strided <= 1'b0;
            op_stride  <= '0;
            op_vd      <= '0;
            op_wdata   <= '0;
            op_mask    <= '0;
            op_err     <= 1'b0;
            cur_addr   <= '0;
            cnt        <= '0;
            asm_buf    <= '0;
        end else begin
            if (accept) begin
                op_store   <= req_store;
                op_strided <= req_strided;
                op_stride  <= req_stride;
                op_vd      <= req_vd;
                op_wdata   <= PW'(req_wdata);
                op_mask    <= req_mask_eff;
                op_err     <= 1'b0;
                cur_addr   <= req_base;
                cnt        <= '0;
                asm_buf    <= '0;
            end
            if (state == S_CHECK) begin
                op_err <= fault;
                cnt    <= '0;
            end
            if (resp_go) begin
                if (op_strided) begin
                    asm_buf <= (asm_buf & ~(PW'(32'hFFFF_FFFF) << {cnt, 5'b0}))
                             | (PW'(32'(mem_resp_data >> {lane_idx, 5'b0})) << {cnt, 5'b0});
                end else begin
                    asm_buf <= (asm_buf & ~(PW'({MEM_WIDTH{1'b1}}) << beat_shift))
                             | (PW'(mem_resp_data) << beat_shift);
                end
            end
            if ((issue_go || resp_go) && !last_beat) begin
                cnt      <= cnt + CW'(1);
                cur_addr <= cur_addr + step;
            end
        end
    end

endmodule

// File: tb/tb_vector_mem_unit.sv
// tb_vector_mem_unit: directed bench for vector_mem_unit (default build,
// VLEN=2, 64-bit beats). A byte-level memory model answers beats, a request
// model predicts beats and completions, and one compare process checks the
// DUT against those predictions on every clock.

module tb_vector_mem_unit;

    localparam int VLEN = 2;
    localparam int MW   = 64;
    localparam int AW   = 32;
    localparam int DW   = 32 * VLEN;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            req_valid, req_ready, req_store, req_strided;
    logic [AW-1:0]   req_base, req_stride;
    logic [4:0]      req_vd;
    logic [DW-1:0]   req_wdata;
`ifdef VECTOR_MEM_UNIT_MASK_EN
    logic [VLEN-1:0] req_mask = '1;
`endif
    logic            mem_req_valid, mem_req_ready, mem_req_wen;
    logic [AW-1:0]   mem_req_addr;
    logic [MW-1:0]   mem_req_wdata;
    logic [MW/8-1:0] mem_req_wmask;
    logic            mem_resp_valid;
    logic [MW-1:0]   mem_resp_data;
    logic            resp_valid, resp_ready, resp_error;
    logic [4:0]      resp_vd;
    logic [DW-1:0]   resp_data;
    logic [2:0]      dbg_state;

    vector_mem_unit #(.VLEN(VLEN), .MEM_WIDTH(MW), .ADDR_WIDTH(AW)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_strided(req_strided), .req_base(req_base), .req_stride(req_stride),
        .req_vd(req_vd), .req_wdata(req_wdata),
`ifdef VECTOR_MEM_UNIT_MASK_EN
        .req_mask(req_mask),
`endif
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_vd(resp_vd),
        .resp_data(resp_data), .resp_error(resp_error), .dbg_state(dbg_state)
    );

    typedef struct {
        logic [AW-1:0]   addr;
        logic            wen;
        logic [MW-1:0]   wdata;
        logic [MW/8-1:0] wmask;
    } beat_t;

    typedef struct {
        logic [4:0]    vd;
        logic [DW-1:0] data;
        logic          err;
        int            lat;
    } resp_t;

    int              checks = 0;
    int              failures = 0;
    int              cyc = 0;
    int              acc_cyc = 0;
    int              op_beats = 0;
    int              stall_left = 0;
    bit              auto_resp = 1'b1;
    bit              rd_pend = 1'b0;
    logic [MW-1:0]   rd_data = '0;
    beat_t           exp_beats[$];
    resp_t           exp_resps[$];
    logic [MW-1:0]   mem[logic [AW-1:0]];
    logic [AW-1:0]   obs_addr[$];
    logic [MW/8-1:0] obs_wmask[$];
    logic [DW-1:0]   last_resp_data = '0;
    logic            last_resp_err = 1'b0;

    // Clock and cycle counter
    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    function automatic logic [MW-1:0] mem_rd(input logic [AW-1:0] a);
        if (mem.exists(a)) return mem[a];
        return {~a, a};
    endfunction

    function automatic logic [MW-1:0] byte_bits(input logic [MW/8-1:0] m);
        logic [MW-1:0] r;
        r = '0;
        for (int k = 0; k < MW / 8; k++) if (m[k]) r = r | (64'hFF << (8 * k));
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Memory side: read data one cycle after an accepted read beat; ready from stall budget
    initial begin
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        mem_req_ready  = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            mem_resp_valid = 1'b0;
            mem_resp_data  = '0;
            if (rd_pend) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = rd_data;
                rd_pend        = 1'b0;
            end
            mem_req_ready = (stall_left == 0);
        end
    end

    // Compare process: beats and completions against the model, every cycle
    initial begin
        logic          held;
        logic [AW-1:0] p_addr;
        logic [MW-1:0] p_wdata;
        logic [7:0]    p_wmask;
        beat_t         b;
        resp_t         r;
        logic [MW-1:0] old, bm;
        held = 1'b0;
        p_addr = '0; p_wdata = '0; p_wmask = '0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                held = 1'b0;
            end else begin
                if (mem_req_valid) begin
                    if (exp_beats.size() == 0) begin
                        check("stray_beat_valid", 64'(mem_req_valid), 64'd0);
                    end else begin
                        b = exp_beats[0];
                        check("beat_addr", 64'(mem_req_addr), 64'(b.addr));
                        check("beat_wen", 64'(mem_req_wen), 64'(b.wen));
                        if (b.wen) begin
                            check("beat_wmask", 64'(mem_req_wmask), 64'(b.wmask));
                            bm = byte_bits(b.wmask);
                            check("beat_wdata", mem_req_wdata & bm, b.wdata & bm);
                        end
                    end
                    if (held) begin
                        check("stall_addr_stable", 64'(mem_req_addr), 64'(p_addr));
                        check("stall_wdata_stable", mem_req_wdata, p_wdata);
                        check("stall_wmask_stable", 64'(mem_req_wmask), 64'(p_wmask));
                    end
                    if (mem_req_ready) begin
                        if (exp_beats.size() != 0) void'(exp_beats.pop_front());
                        op_beats++;
                        obs_addr.push_back(mem_req_addr);
                        obs_wmask.push_back(mem_req_wmask);
                        if (mem_req_wen) begin
                            old = mem_rd(mem_req_addr);
                            bm = byte_bits(mem_req_wmask);
                            mem[mem_req_addr] = (old & ~bm) | (mem_req_wdata & bm);
                        end else if (auto_resp) begin
                            rd_pend = 1'b1;
                            rd_data = mem_rd(mem_req_addr);
                        end
                        held = 1'b0;
                    end else begin
                        held    = 1'b1;
                        p_addr  = mem_req_addr;
                        p_wdata = mem_req_wdata;
                        p_wmask = mem_req_wmask;
                        if (stall_left > 0) stall_left--;
                    end
                end else begin
                    held = 1'b0;
                end
                if (resp_valid) begin
                    if (exp_resps.size() == 0) begin
                        check("stray_resp_valid", 64'(resp_valid), 64'd0);
                    end else begin
                        r = exp_resps[0];
                        check("resp_vd", 64'(resp_vd), 64'(r.vd));
                        check("resp_data", resp_data, r.data);
                        check("resp_error", 64'(resp_error), 64'(r.err));
                        if (r.lat >= 0) check("resp_latency", 64'(cyc - acc_cyc), 64'(r.lat));
                        if (resp_ready) begin
                            void'(exp_resps.pop_front());
                            last_resp_data = resp_data;
                            last_resp_err  = resp_error;
                        end
                    end
                end
            end
        end
    end

    // Predict beats and completion of one request from the address rules
    task automatic model_op(input bit st, input bit strided, input logic [AW-1:0] base,
                            input logic [AW-1:0] stride, input logic [4:0] vd,
                            input logic [DW-1:0] wd, input bit zero_wait, output int nb);
        beat_t         b;
        resp_t         r;
        bit            flt;
        logic [AW-1:0] a, ba;
        logic [31:0]   word, elem;
        logic [MW-1:0] t;
        nb = 0;
        flt = strided ? ((base[1:0] != 0) || (stride[1:0] != 0)) : (base[2:0] != 0);
        r.vd = vd; r.err = flt; r.data = '0;
        if (!flt) begin
            if (!strided) begin
                b.addr = base; b.wen = st; b.wdata = wd; b.wmask = st ? 8'hFF : 8'h00;
                exp_beats.push_back(b);
                nb = 1;
                if (!st) r.data = mem_rd(base);
            end else begin
                for (int i = 0; i < VLEN; i++) begin
                    a    = base + stride * 32'(i);
                    ba   = a & ~32'h7;
                    word = 32'(wd >> (32 * i));
                    b.addr  = ba;
                    b.wen   = st;
                    b.wdata = a[2] ? {word, 32'h0} : {32'h0, word};
                    b.wmask = st ? (a[2] ? 8'hF0 : 8'h0F) : 8'h00;
                    exp_beats.push_back(b);
                    nb++;
                    if (!st) begin
                        t = mem_rd(ba);
                        elem = a[2] ? t[63:32] : t[31:0];
                        r.data = r.data | (64'(elem) << (32 * i));
                    end
                end
            end
        end
        r.lat = !zero_wait ? -1 : (flt ? 2 : (st ? 2 + nb : 2 + 2 * nb));
        exp_resps.push_back(r);
    endtask

    task automatic drive_req(input bit st, input bit strided, input logic [AW-1:0] base,
                             input logic [AW-1:0] stride, input logic [4:0] vd,
                             input logic [DW-1:0] wd);
        bit ok;
        ok = 1'b0;
        @(posedge clock); #1;
        req_valid = 1'b1; req_store = st; req_strided = strided;
        req_base = base; req_stride = stride; req_vd = vd; req_wdata = wd;
        for (int t = 0; t < 50; t++) begin
            @(negedge clock);
            if (req_ready) begin
                acc_cyc = cyc;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("req_accept_timeout", 64'd0, 64'd1);
        @(posedge clock); #1;
        req_valid = 1'b0;
    endtask

    task automatic run_op(input bit st, input bit strided, input logic [AW-1:0] base,
                          input logic [AW-1:0] stride, input logic [4:0] vd,
                          input logic [DW-1:0] wd, input bit zero_wait);
        int nb;
        bit ok;
        op_beats = 0;
        obs_addr.delete();
        obs_wmask.delete();
        model_op(st, strided, base, stride, vd, wd, zero_wait, nb);
        drive_req(st, strided, base, stride, vd, wd);
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clock);
            if (exp_resps.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("resp_timeout", 64'd0, 64'd1);
            exp_resps.delete();
        end
        check("beat_count", 64'(op_beats), 64'(nb));
        exp_beats.delete();
    endtask

    initial begin
        logic [MW-1:0] t;
        bit ok;
        req_valid = 1'b0; req_store = 1'b0; req_strided = 1'b0;
        req_base = '0; req_stride = '0; req_vd = '0; req_wdata = '0;
        resp_ready = 1'b1;

        // Reset values
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        check("rst_mem_req_addr", 64'(mem_req_addr), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_data", resp_data, 64'd0);
        check("rst_resp_error", 64'(resp_error), 64'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("post_rst_req_ready", 64'(req_ready), 64'd1);

        // Unit load
        mem[32'h0800_0100] = 64'hdeadbeef_deadbeef;
        run_op(1'b0, 1'b0, 32'h0800_0100, 32'd0, 5'd2, 64'd0, 1'b1);
        check("unit_load_data", last_resp_data, 64'hdeadbeef_deadbeef);
        check("unit_load_addr", 64'(obs_addr[0]), 64'h0800_0100);

        // Strided load, stride 12: lane 0 of 0x100, lane 1 of 0x108
        mem[32'h100] = 64'h11111111_AAAAAAAA;
        mem[32'h108] = 64'hBBBBBBBB_22222222;
        run_op(1'b0, 1'b1, 32'h100, 32'd12, 5'd3, 64'd0, 1'b1);
        check("str_load_data", last_resp_data, 64'hBBBBBBBB_AAAAAAAA);
        check("str_load_addr1", 64'(obs_addr[1]), 64'h108);

        // Strided store, stride -4
        run_op(1'b1, 1'b1, 32'h200, 32'hFFFF_FFFC, 5'd4, 64'h12345671_12345670, 1'b1);
        check("str_store_mask0", 64'(obs_wmask[0]), 64'h0F);
        check("str_store_mask1", 64'(obs_wmask[1]), 64'hF0);
        check("str_store_addr1", 64'(obs_addr[1]), 64'h1F8);
        t = mem_rd(32'h200);
        check("str_store_lane0", 64'(t[31:0]), 64'h12345670);
        t = mem_rd(32'h1F8);
        check("str_store_lane1", 64'(t[63:32]), 64'h12345671);
        check("store_resp_data", last_resp_data, 64'd0);

        // Unit store then read back
        run_op(1'b1, 1'b0, 32'h300, 32'd0, 5'd5, 64'hCAFEF00D_01234567, 1'b1);
        run_op(1'b0, 1'b0, 32'h300, 32'd0, 5'd6, 64'd0, 1'b1);
        check("unit_roundtrip", last_resp_data, 64'hCAFEF00D_01234567);

        // Alignment faults: no beats, error flagged
        run_op(1'b0, 1'b0, 32'h104, 32'd0, 5'd7, 64'd0, 1'b1);
        check("fault_unit_err", 64'(last_resp_err), 64'd1);
        run_op(1'b0, 1'b1, 32'h100, 32'd6, 5'd8, 64'd0, 1'b1);
        check("fault_stride_err", 64'(last_resp_err), 64'd1);
        run_op(1'b1, 1'b1, 32'h102, 32'd4, 5'd9, 64'h1, 1'b1);

        // Zero stride and address wrap-around
        mem[32'h400] = 64'h44444444_33333333;
        run_op(1'b0, 1'b1, 32'h404, 32'd0, 5'd10, 64'd0, 1'b1);
        check("zero_stride_data", last_resp_data, 64'h44444444_44444444);
        run_op(1'b0, 1'b1, 32'hFFFF_FFFC, 32'd8, 5'd11, 64'd0, 1'b1);

        // Backpressure: ready low for 3 cycles on a load and on a strided store
        stall_left = 3; mem_req_ready = 1'b0;
        run_op(1'b0, 1'b0, 32'h500, 32'd0, 5'd12, 64'd0, 1'b0);
        stall_left = 3; mem_req_ready = 1'b0;
        run_op(1'b1, 1'b1, 32'h520, 32'd4, 5'd13, 64'h5555AAAA_A5A5A5A5, 1'b0);

        // Reset while waiting for read data, then a late response
        auto_resp = 1'b0;
        op_beats = 0;
        begin
            beat_t b;
            b.addr = 32'h600; b.wen = 1'b0; b.wdata = '0; b.wmask = '0;
            exp_beats.push_back(b);
        end
        drive_req(1'b0, 1'b0, 32'h600, 32'd0, 5'd14, 64'd0);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (op_beats == 1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("rst_mid_beat_timeout", 64'd0, 64'd1);
        @(posedge clock); #1;
        reset = 1'b0;
        exp_beats.delete();
        exp_resps.delete();
        @(negedge clock);
        check("mid_rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        check("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
        check("mid_rst_req_ready", 64'(req_ready), 64'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock); #1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'hBAD0BAD0_BAD0BAD0;
        @(negedge clock);
        check("late_resp_req_ready", 64'(req_ready), 64'd1);
        check("late_resp_resp_valid", 64'(resp_valid), 64'd0);
        check("late_resp_mem_valid", 64'(mem_req_valid), 64'd0);
        auto_resp = 1'b1;
        mem[32'h700] = 64'h77777777_70707070;
        run_op(1'b0, 1'b0, 32'h700, 32'd0, 5'd15, 64'd0, 1'b1);
        check("post_rst_load_data", last_resp_data, 64'h77777777_70707070);

        repeat (3) @(posedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
